miriscv_decode_stage: RTL and testbench
=======================================

Name: miriscv_decode_stage

Overview:
- Registered, parametrised RV32I decode pipeline stage between fetch and execute.
- Buffers fetched {pc, instr} pairs in an IBUF_DEPTH-entry FIFO and decodes the FIFO head into a registered control bundle.
- Uses valid/ready handshakes on both sides, supports flush, and keeps a saturating illegal-instruction counter.
- Decode rules and field encodings follow miriscv_defines.v (ALU_*, OP_A_*, OP_B_*, LDST_*, WB_*).

Parameters:
- IBUF_DEPTH, 4, instruction FIFO entries; power of two, >=2.
- PC_W, 32, width of carried PC.
- ILL_CNT_W, 8, illegal-instruction counter width.

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  asynchronous active-low reset
- in_valid_i  in  1  fetch offers instruction
- in_ready_o  out  1  FIFO not full
- in_instr_i  in  32  fetched instruction
- in_pc_i  in  PC_W  instruction address
- flush_i  in  1  discard all buffered/decoded instructions
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  execute accepts bundle
- out_pc_o  out  PC_W  PC of decoded instruction
- out_instr_o  out  32  raw instruction
- ex_op_a_sel_o  out  2  operand A select
- ex_op_b_sel_o  out  3  operand B select
- alu_op_o  out  ALU_OP_WIDTH  ALU operation
- mem_req_o, mem_we_o  out  1 each  LSU request / write
- mem_size_o  out  3  LSU size
- gpr_we_a_o  out  1  register write enable
- wb_src_sel_o  out  1  writeback source
- branch_o, jal_o, jalr_o  out  1 each  control-flow type
- illegal_instr_o  out  1  instruction illegal
- ill_cnt_o  out  ILL_CNT_W  saturating illegal count

Behaviour:
- Reset (async, arstn_i=0): FIFO empty, out_valid_o=0, ill_cnt_o=0, out_pc_o/out_instr_o=0, ex_op_a_sel_o=OP_A_RS1, ex_op_b_sel_o=OP_B_RS2, alu_op_o=ALU_ADD, mem_size_o=LDST_B, wb_src_sel_o=WB_EX_RESULT, all 1-bit controls 0. A reset mid-operation drops all in-flight entries.
- FIFO push: in_valid_i & in_ready_o. in_ready_o = !full (combinational from count). There is no pass-through when full, even if a pop occurs in the same cycle.
- Pointers wrap modulo IBUF_DEPTH. Count width is clog2(IBUF_DEPTH)+1. Simultaneous push and pop leaves count unchanged.
- Output register load: FIFO non-empty & (!out_valid_o | out_ready_i). This pops the head and registers the decoded bundle. If out_valid_o & !out_ready_i, the bundle holds stable.
- Latency: instruction pushed at edge N gives out_valid_o=1 after edge N+1 (2-cycle minimum). Throughput is 1 per cycle with out_ready_i=1.
- When out_valid_o=0, control outputs hold their last values. Consumers must qualify with out_valid_o.
- Illegal instruction (opcode[1:0]!=2'b11, unknown opcode, unknown funct3/funct7): illegal_instr_o=1 and gpr_we_a_o, mem_req_o, mem_we_o, branch_o, jal_o, jalr_o forced 0. Selects and alu_op_o take reset defaults.
- MISC_MEM and SYSTEM decode as legal no-ops: gpr_we_a_o=0, no memory request.
- ill_cnt_o increments by 1 on each output-register load of an illegal instruction, saturating at all-ones. It is not cleared by flush.
- flush_i (priority over everything except reset): FIFO emptied, out_valid_o=0 next cycle, any push in the same cycle discarded, no pop counted.

Optional Feature:
- MIRISCV_MULDIV_EN defined: adds output mdu_req_o (1) and mdu_op_o (3, = funct3). OP opcode with funct7=7'h01 is legal: mdu_req_o=1, gpr_we_a_o=1, op_a=OP_A_RS1, op_b=OP_B_RS2, alu_op_o=ALU_ADD.
- Undefined: mdu ports are absent, and funct7=7'h01 is illegal.

Test Plan:
- Reset, push 0x00500093 (addi x1,x0,5) with out_ready_i=1 -> out_valid_o=1 two edges later; alu_op_o=ALU_ADD, ex_op_b_sel_o=OP_B_IMM_I, gpr_we_a_o=1, illegal_instr_o=0.
- out_ready_i=0, push continuously -> 5 accepted (4 FIFO + 1 output reg), in_ready_o=0; release ready -> in-order drain, one per cycle.
- Push 0x00000000 then 0xFFFFFFFF -> illegal_instr_o=1 for both, gpr_we_a_o=0, ill_cnt_o=2; with ILL_CNT_W=2, 5 illegals -> ill_cnt_o=3.
- Fill FIFO, assert flush_i together with in_valid_i -> next cycle FIFO empty, out_valid_o=0, pushed instruction lost, in_ready_o=1.
- Push 0x00812183 (lw) then 0x00112423 (sw) -> first: mem_req_o=1, mem_we_o=0, mem_size_o=LDST_W, wb_src_sel_o=WB_LSU_DATA; second: mem_we_o=1, ex_op_b_sel_o=OP_B_IMM_S, gpr_we_a_o=0.
- Push 0x02208033 (mul) -> with macro: mdu_req_o=1, mdu_op_o=0, legal; without macro: illegal_instr_o=1.

Source files
------------

// File: rtl/miriscv_decode_stage.sv
// RV32I decode stage: IBUF_DEPTH-entry {pc, instr} FIFO feeding a registered control bundle.
// Optional M-extension decode when MIRISCV_MULDIV_EN is defined (adds mdu_req_o / mdu_op_o).
module miriscv_decode_stage #(
   parameter int IBUF_DEPTH = 4,
   parameter int PC_W = 32,
   parameter int ILL_CNT_W = 8,
   localparam int ALU_OP_WIDTH = 5
) (
   input  logic                    clk_i,
   input  logic                    arstn_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [31:0]             in_instr_i,
   input  logic [PC_W-1:0]         in_pc_i,
   input  logic                    flush_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [PC_W-1:0]         out_pc_o,
   output logic [31:0]             out_instr_o,
   output logic [1:0]              ex_op_a_sel_o,
   output logic [2:0]              ex_op_b_sel_o,
   output logic [ALU_OP_WIDTH-1:0] alu_op_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [2:0]              mem_size_o,
   output logic                    gpr_we_a_o,
   output logic                    wb_src_sel_o,
   output logic                    branch_o,
   output logic                    jal_o,
   output logic                    jalr_o,
   output logic                    illegal_instr_o,
`ifdef MIRISCV_MULDIV_EN
   output logic                    mdu_req_o,
   output logic [2:0]              mdu_op_o,
`endif
   output logic [ILL_CNT_W-1:0]    ill_cnt_o
);

   localparam int PTR_W = $clog2(IBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b01000;
   localparam logic [4:0] ALU_XOR  = 5'b00100;
   localparam logic [4:0] ALU_OR   = 5'b00110;
   localparam logic [4:0] ALU_AND  = 5'b00111;
   localparam logic [4:0] ALU_SRA  = 5'b01101;
   localparam logic [4:0] ALU_SRL  = 5'b00101;
   localparam logic [4:0] ALU_SLL  = 5'b00001;
   localparam logic [4:0] ALU_LTS  = 5'b10100;
   localparam logic [4:0] ALU_LTU  = 5'b10110;
   localparam logic [4:0] ALU_GES  = 5'b10101;
   localparam logic [4:0] ALU_GEU  = 5'b10111;
   localparam logic [4:0] ALU_EQ   = 5'b11000;
   localparam logic [4:0] ALU_NE   = 5'b11001;
   localparam logic [4:0] ALU_SLTS = 5'b00010;
   localparam logic [4:0] ALU_SLTU = 5'b00011;

   localparam logic [1:0] OP_A_CURR_PC = 2'd1;
   localparam logic [1:0] OP_A_ZERO    = 2'd2;
   localparam logic [2:0] OP_B_IMM_I   = 3'd1;
   localparam logic [2:0] OP_B_IMM_U   = 3'd2;
   localparam logic [2:0] OP_B_IMM_S   = 3'd3;
   localparam logic [2:0] OP_B_INCR    = 3'd4;
   localparam logic       WB_LSU_DATA  = 1'b1;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Every reset-default field (RS1, RS2, ADD, LDST_B, EX_RESULT) encodes as zero,
   // so '0 doubles as the reset value and the illegal-instruction bundle.
   typedef struct packed {
      logic [1:0] op_a;
      logic [2:0] op_b;
      logic [4:0] alu;
      logic       mem_req;
      logic       mem_we;
      logic [2:0] mem_size;
      logic       gpr_we;
      logic       wb_src;
      logic       branch;
      logic       jal;
      logic       jalr;
      logic       illegal;
      logic       mdu_req;
      logic [2:0] mdu_op;
   } ctrl_t;

   function automatic logic [4:0] alu_arith(input logic [2:0] f3);
      case (f3)
         3'd0:    return ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLTS;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   logic [PC_W-1:0]  pc_buf_q  [IBUF_DEPTH];
   logic [PC_W-1:0]  pc_buf_d  [IBUF_DEPTH];
   logic [31:0]      ins_buf_q [IBUF_DEPTH];
   logic [31:0]      ins_buf_d [IBUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [PC_W-1:0]  out_pc_q, out_pc_d;
   logic [31:0]      out_instr_q, out_instr_d;
   ctrl_t            ctrl_q, ctrl_d, dec;
   logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

   logic        push, load, legal;
   logic [31:0] head_instr;
   logic [6:0]  opc, f7;
   logic [2:0]  f3;

   assign in_ready_o = (cnt_q != CNT_W'(IBUF_DEPTH));
   assign push       = in_valid_i & in_ready_o & ~flush_i;
   assign load       = (cnt_q != '0) & (~out_valid_q | out_ready_i) & ~flush_i;
   assign head_instr = ins_buf_q[rd_ptr_q];
   assign opc        = head_instr[6:0];
   assign f3         = head_instr[14:12];
   assign f7         = head_instr[31:25];

   always_comb begin
      dec   = '0;
      legal = 1'b1;
      case (opc)
         OPC_LOAD: begin
            legal        = (f3 == 3'd0) | (f3 == 3'd1) | (f3 == 3'd2) | (f3 == 3'd4) | (f3 == 3'd5);
            dec.op_b     = OP_B_IMM_I;
            dec.mem_req  = 1'b1;
            dec.mem_size = f3;
            dec.gpr_we   = 1'b1;
            dec.wb_src   = WB_LSU_DATA;
         end
         OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
         OPC_OP_IMM: begin
            dec.op_b   = OP_B_IMM_I;
            dec.gpr_we = 1'b1;
            dec.alu    = alu_arith(f3);
            if (f3 == 3'd1) legal = (f7 == 7'h00);
            if (f3 == 3'd5) begin
               legal = (f7 == 7'h00) | (f7 == 7'h20);
               if (f7 == 7'h20) dec.alu = ALU_SRA;
            end
         end
         OPC_AUIPC: begin
            dec.op_a   = OP_A_CURR_PC;
            dec.op_b   = OP_B_IMM_U;
            dec.gpr_we = 1'b1;
         end
         OPC_STORE: begin
            legal        = (f3 < 3'd3);
            dec.op_b     = OP_B_IMM_S;
            dec.mem_req  = 1'b1;
            dec.mem_we   = 1'b1;
            dec.mem_size = f3;
         end
         OPC_OP: begin
            dec.gpr_we = 1'b1;
            case (f7)
               7'h00: dec.alu = alu_arith(f3);
               7'h20: begin
                  legal   = (f3 == 3'd0) | (f3 == 3'd5);
                  dec.alu = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
               end
`ifdef MIRISCV_MULDIV_EN
               7'h01: begin
                  dec.mdu_req = 1'b1;
                  dec.mdu_op  = f3;
               end
`endif
               default: legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            dec.op_a   = OP_A_ZERO;
            dec.op_b   = OP_B_IMM_U;
            dec.gpr_we = 1'b1;
         end
         OPC_BRANCH: begin
            dec.branch = 1'b1;
            case (f3)
               3'd0:    dec.alu = ALU_EQ;
               3'd1:    dec.alu = ALU_NE;
               3'd4:    dec.alu = ALU_LTS;
               3'd5:    dec.alu = ALU_GES;
               3'd6:    dec.alu = ALU_LTU;
               3'd7:    dec.alu = ALU_GEU;
               default: legal   = 1'b0;
            endcase
         end
         OPC_JAL: begin
            dec.op_a   = OP_A_CURR_PC;
            dec.op_b   = OP_B_INCR;
            dec.jal    = 1'b1;
            dec.gpr_we = 1'b1;
         end
         OPC_JALR: begin
            legal      = (f3 == 3'd0);
            dec.op_a   = OP_A_CURR_PC;
            dec.op_b   = OP_B_INCR;
            dec.jalr   = 1'b1;
            dec.gpr_we = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   always_comb begin
      pc_buf_d    = pc_buf_q;
      ins_buf_d   = ins_buf_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      ctrl_d      = ctrl_q;
      ill_cnt_d   = ill_cnt_q;
      if (flush_i) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         if (push) begin
            pc_buf_d[wr_ptr_q]  = in_pc_i;
            ins_buf_d[wr_ptr_q] = in_instr_i;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
         end
         if (load) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
            out_pc_d    = pc_buf_q[rd_ptr_q];
            out_instr_d = head_instr;
            ctrl_d      = dec;
            if (dec.illegal && !(&ill_cnt_q)) ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
         end else if (out_ready_i) begin
            out_valid_d = 1'b0;
         end
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(load);
      end
   end

   // Buffer storage needs no reset: cnt_q gates every read.
   always_ff @(posedge clk_i) begin
      pc_buf_q  <= pc_buf_d;
      ins_buf_q <= ins_buf_d;
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_instr_q <= '0;
         ctrl_q      <= '0;
         ill_cnt_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
         ctrl_q      <= ctrl_d;
         ill_cnt_q   <= ill_cnt_d;
      end
   end

   assign out_valid_o     = out_valid_q;
   assign out_pc_o        = out_pc_q;
   assign out_instr_o     = out_instr_q;
   assign ex_op_a_sel_o   = ctrl_q.op_a;
   assign ex_op_b_sel_o   = ctrl_q.op_b;
   assign alu_op_o        = ctrl_q.alu;
   assign mem_req_o       = ctrl_q.mem_req;
   assign mem_we_o        = ctrl_q.mem_we;
   assign mem_size_o      = ctrl_q.mem_size;
   assign gpr_we_a_o      = ctrl_q.gpr_we;
   assign wb_src_sel_o    = ctrl_q.wb_src;
   assign branch_o        = ctrl_q.branch;
   assign jal_o           = ctrl_q.jal;
   assign jalr_o          = ctrl_q.jalr;
   assign illegal_instr_o = ctrl_q.illegal;
   assign ill_cnt_o       = ill_cnt_q;
`ifdef MIRISCV_MULDIV_EN
   assign mdu_req_o       = ctrl_q.mdu_req;
   assign mdu_op_o        = ctrl_q.mdu_op;
`endif

endmodule

// File: tb/tb_miriscv_decode_stage.sv
// Bench for miriscv_decode_stage: directed scenarios plus random traffic against a queue-based model.
// A second instance with ILL_CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_miriscv_decode_stage;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic arstn = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [31:0] in_instr = '0, in_pc = '0;

   logic        in_ready, out_valid, mem_req, mem_we, gpr_we, wb_src, branch, jal, jalr, illegal;
   logic [31:0] out_pc, out_instr;
   logic [1:0]  op_a;
   logic [2:0]  op_b, mem_size;
   logic [4:0]  alu;
   logic [7:0]  ill_cnt;
   logic        mdu_req;
   logic [2:0]  mdu_op;

   logic        d2_in_ready, d2_out_valid, d2_mem_req, d2_mem_we, d2_gpr_we, d2_wb_src;
   logic        d2_branch, d2_jal, d2_jalr, d2_illegal;
   logic [31:0] d2_out_pc, d2_out_instr;
   logic [1:0]  d2_op_a;
   logic [2:0]  d2_op_b, d2_mem_size;
   logic [4:0]  d2_alu;
   logic [1:0]  d2_ill_cnt;
`ifdef MIRISCV_MULDIV_EN
   logic        d2_mdu_req;
   logic [2:0]  d2_mdu_op;
`else
   assign mdu_req = 1'b0;
   assign mdu_op  = 3'd0;
`endif

   miriscv_decode_stage #(.IBUF_DEPTH(DEPTH), .PC_W(32), .ILL_CNT_W(8)) dut (
      .clk_i(clk), .arstn_i(arstn), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_instr_i(in_instr), .in_pc_i(in_pc), .flush_i(flush), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_pc_o(out_pc), .out_instr_o(out_instr),
      .ex_op_a_sel_o(op_a), .ex_op_b_sel_o(op_b), .alu_op_o(alu), .mem_req_o(mem_req),
      .mem_we_o(mem_we), .mem_size_o(mem_size), .gpr_we_a_o(gpr_we), .wb_src_sel_o(wb_src),
      .branch_o(branch), .jal_o(jal), .jalr_o(jalr), .illegal_instr_o(illegal),
`ifdef MIRISCV_MULDIV_EN
      .mdu_req_o(mdu_req), .mdu_op_o(mdu_op),
`endif
      .ill_cnt_o(ill_cnt));

   miriscv_decode_stage #(.IBUF_DEPTH(DEPTH), .PC_W(32), .ILL_CNT_W(2)) dut2 (
      .clk_i(clk), .arstn_i(arstn), .in_valid_i(in_valid), .in_ready_o(d2_in_ready),
      .in_instr_i(in_instr), .in_pc_i(in_pc), .flush_i(flush), .out_valid_o(d2_out_valid),
      .out_ready_i(out_ready), .out_pc_o(d2_out_pc), .out_instr_o(d2_out_instr),
      .ex_op_a_sel_o(d2_op_a), .ex_op_b_sel_o(d2_op_b), .alu_op_o(d2_alu), .mem_req_o(d2_mem_req),
      .mem_we_o(d2_mem_we), .mem_size_o(d2_mem_size), .gpr_we_a_o(d2_gpr_we), .wb_src_sel_o(d2_wb_src),
      .branch_o(d2_branch), .jal_o(d2_jal), .jalr_o(d2_jalr), .illegal_instr_o(d2_illegal),
`ifdef MIRISCV_MULDIV_EN
      .mdu_req_o(d2_mdu_req), .mdu_op_o(d2_mdu_op),
`endif
      .ill_cnt_o(d2_ill_cnt));

   // Observed bundle: {op_a, op_b, alu, mem_req, mem_we, mem_size, gpr_we, wb, br, jal, jalr, ill, mdu_req, mdu_op}
   logic [24:0] act;
   assign act = {op_a, op_b, alu, mem_req, mem_we, mem_size, gpr_we, wb_src, branch, jal, jalr,
                 illegal, mdu_req, mdu_op};

   int n_tests = 0, n_fail = 0;

   localparam logic [4:0] ARITH  [8] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                         5'b00100, 5'b00101, 5'b00110, 5'b00111};
   localparam logic [4:0] BRTAB  [8] = '{5'b11000, 5'b11001, 5'b00000, 5'b00000,
                                         5'b10100, 5'b10101, 5'b10110, 5'b10111};
   localparam logic [6:0] OPCS  [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                         7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

   function automatic logic [24:0] ref_dec(input logic [31:0] i);
      logic [6:0] opc, f7;
      logic [2:0] f3, b, sz, mo;
      logic [1:0] a;
      logic [4:0] op;
      logic rq, we, gw, wb, br, jl, jr, ok, md;
      opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
      a = 2'd0; b = 3'd0; op = 5'd0; sz = 3'd0; mo = 3'd0;
      rq = 0; we = 0; gw = 0; wb = 0; br = 0; jl = 0; jr = 0; ok = 0; md = 0;
      case (opc)
         7'h03: begin ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); b = 3'd1; rq = 1; sz = f3; gw = 1; wb = 1; end
         7'h0F, 7'h73: ok = 1;
         7'h13: begin
            ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            b = 3'd1; gw = 1;
            op = (f3 == 3'd5 && f7 == 7'h20) ? 5'b01101 : ARITH[f3];
         end
         7'h17: begin ok = 1; a = 2'd1; b = 3'd2; gw = 1; end
         7'h23: begin ok = (f3 < 3'd3); b = 3'd3; rq = 1; we = 1; sz = f3; end
         7'h33: begin
            gw = 1;
            if (f7 == 7'h00) begin ok = 1; op = ARITH[f3]; end
            else if (f7 == 7'h20) begin ok = (f3 == 3'd0 || f3 == 3'd5); op = (f3 == 3'd0) ? 5'b01000 : 5'b01101; end
`ifdef MIRISCV_MULDIV_EN
            else if (f7 == 7'h01) begin ok = 1; md = 1; mo = f3; end
`endif
         end
         7'h37: begin ok = 1; a = 2'd2; b = 3'd2; gw = 1; end
         7'h63: begin ok = (f3 != 3'd2 && f3 != 3'd3); br = 1; op = BRTAB[f3]; end
         7'h6F: begin ok = 1; a = 2'd1; b = 3'd4; jl = 1; gw = 1; end
         7'h67: begin ok = (f3 == 3'd0); a = 2'd1; b = 3'd4; jr = 1; gw = 1; end
         default: ok = 0;
      endcase
      if (!ok) return 25'h10;
      return {a, b, op, rq, we, sz, gw, wb, br, jl, jr, 1'b0, md, mo};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom % 8 != 0) r[6:0] = OPCS[$urandom % 11];
      case ($urandom % 4)
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         2: r[31:25] = 7'h01;
         default: ;
      endcase
      return r;
   endfunction

   // Model: FIFO contents as a queue, plus the output register and both counters.
   typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
   ent_t        mq[$];
   bit          mo_v;
   logic [31:0] mo_pc, mo_ins;
   int          m_ill, m_ill2;

   task automatic tick();
      ent_t e;
      bit do_push;
      logic [24:0] d;
      @(posedge clk);
      if (flush) begin
         mq.delete();
         mo_v = 0;
      end else begin
         do_push = in_valid && (mq.size() < DEPTH);
         if (mq.size() > 0 && (!mo_v || out_ready)) begin
            e = mq.pop_front();
            mo_v = 1; mo_pc = e.pc; mo_ins = e.ins;
            d = ref_dec(e.ins);
            if (d[4]) begin
               if (m_ill < 255) m_ill++;
               if (m_ill2 < 3) m_ill2++;
            end
         end else if (out_ready) begin
            mo_v = 0;
         end
         if (do_push) begin
            e.pc = in_pc; e.ins = in_instr;
            mq.push_back(e);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0; flush = 0; out_ready = 0;
      #2 arstn = 0;
      mq.delete(); mo_v = 0; m_ill = 0; m_ill2 = 0;
      @(negedge clk);
      arstn = 1;
      #1;
   endtask

   task automatic push_seq(input logic [31:0] pc, input logic [31:0] ins);
      in_valid = 1; in_pc = pc; in_instr = ins;
      tick();
      in_valid = 0;
   endtask

   task automatic test_reset();
      do_reset();
      out_ready = 1;
      push_seq(32'h40, 32'h0);
      push_seq(32'h44, 32'h00500093);
      tick(); tick();
      out_ready = 0;
      push_seq(32'h48, 32'h00500093);
      push_seq(32'h4C, 32'h00500093);
      #2 arstn = 0;
      mq.delete(); mo_v = 0; m_ill = 0; m_ill2 = 0;
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", in_ready); end
      n_tests++; if (ill_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ill_cnt got %0d want 0", ill_cnt); end
      n_tests++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin n_fail++;
         $display("FAIL reset_pc_instr got %h/%h want 0/0", out_pc, out_instr); end
      n_tests++; if (act !== 25'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", act); end
      @(negedge clk); arstn = 1;
      out_ready = 1;
      tick(); tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drops_inflight got %0b want 0", out_valid); end
   endtask

   task automatic test_addi();
      do_reset();
      out_ready = 1;
      push_seq(32'h100, 32'h00500093);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_latency1 got %0b want 0", out_valid); end
      tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0b want 1", out_valid); end
      n_tests++; if (alu !== 5'd0 || op_b !== 3'd1 || op_a !== 2'd0) begin n_fail++;
         $display("FAIL addi_sel got alu=%h b=%0d a=%0d want 0/1/0", alu, op_b, op_a); end
      n_tests++; if (gpr_we !== 1'b1 || illegal !== 1'b0) begin n_fail++;
         $display("FAIL addi_we_ill got %0b/%0b want 1/0", gpr_we, illegal); end
      n_tests++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc got %h want 100", out_pc); end
      tick();
   endtask

   task automatic test_back_to_back();
      int acc = 0;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         in_valid = 1;
         in_pc    = 32'h200 + 32'(4 * acc);
         in_instr = {12'(acc), 5'd0, 3'd0, 5'd1, 7'h13};
         if (in_ready) acc++;
         tick();
      end
      in_valid = 0;
      n_tests++; if (acc != 5) begin n_fail++; $display("FAIL bp_accepted got %0d want 5", acc); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %0b want 0", in_ready); end
      out_ready = 1;
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(4 * k)) begin n_fail++;
            $display("FAIL bp_drain%0d got v=%0b pc=%h want 1/%h", k, out_valid, out_pc, 32'h200 + 32'(4 * k)); end
         tick();
      end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %0b want 0", out_valid); end
   endtask

   task automatic test_illegal();
      do_reset();
      out_ready = 1;
      in_valid = 1; in_pc = 32'h300; in_instr = 32'h0;
      tick();
      in_pc = 32'h304; in_instr = 32'hFFFFFFFF;
      tick();
      in_valid = 0;
      n_tests++; if (out_valid !== 1'b1 || illegal !== 1'b1 || gpr_we !== 1'b0 || ill_cnt !== 8'd1) begin n_fail++;
         $display("FAIL ill_zero got v=%0b ill=%0b we=%0b cnt=%0d want 1/1/0/1", out_valid, illegal, gpr_we, ill_cnt); end
      tick();
      n_tests++; if (out_instr !== 32'hFFFFFFFF || illegal !== 1'b1 || gpr_we !== 1'b0 || ill_cnt !== 8'd2) begin n_fail++;
         $display("FAIL ill_ones got i=%h ill=%0b we=%0b cnt=%0d want ffffffff/1/0/2", out_instr, illegal, gpr_we, ill_cnt); end
      for (int k = 0; k < 3; k++) push_seq(32'h308 + 32'(4 * k), 32'h0000_0000 | 32'(k));
      tick(); tick();
      n_tests++; if (ill_cnt !== 8'd5) begin n_fail++; $display("FAIL ill_cnt5 got %0d want 5", ill_cnt); end
      n_tests++; if (d2_ill_cnt !== 2'd3) begin n_fail++; $display("FAIL ill_sat2 got %0d want 3", d2_ill_cnt); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 6; k++) push_seq(32'h400 + 32'(4 * k), 32'h00500093);
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full got %0b want 0", in_ready); end
      flush = 1; in_valid = 1; in_pc = 32'h500; in_instr = 32'h00700093;
      tick();
      flush = 0; in_valid = 0;
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
         $display("FAIL flush_state got v=%0b r=%0b want 0/1", out_valid, in_ready); end
      out_ready = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_lost%0d got %0b want 0", k, out_valid); end
      end
      n_tests++; if (ill_cnt !== 8'd0) begin n_fail++; $display("FAIL flush_cnt got %0d want 0", ill_cnt); end
   endtask

   task automatic test_ldst();
      do_reset();
      out_ready = 1;
      in_valid = 1; in_pc = 32'h600; in_instr = 32'h00812183;
      tick();
      in_pc = 32'h604; in_instr = 32'h00112423;
      tick();
      in_valid = 0;
      n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_size !== 3'd2 || wb_src !== 1'b1 || gpr_we !== 1'b1) begin n_fail++;
         $display("FAIL lw got rq=%0b we=%0b sz=%0d wb=%0b gw=%0b want 1/0/2/1/1", mem_req, mem_we, mem_size, wb_src, gpr_we); end
      tick();
      n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || op_b !== 3'd3 || gpr_we !== 1'b0) begin n_fail++;
         $display("FAIL sw got rq=%0b we=%0b b=%0d gw=%0b want 1/1/3/0", mem_req, mem_we, op_b, gpr_we); end
      tick();
   endtask

   task automatic test_mul();
      do_reset();
      out_ready = 1;
      push_seq(32'h700, 32'h02208033);
      tick();
`ifdef MIRISCV_MULDIV_EN
      n_tests++; if (mdu_req !== 1'b1 || mdu_op !== 3'd0 || illegal !== 1'b0 || gpr_we !== 1'b1) begin n_fail++;
         $display("FAIL mul got mdu=%0b op=%0d ill=%0b gw=%0b want 1/0/0/1", mdu_req, mdu_op, illegal, gpr_we); end
`else
      n_tests++; if (illegal !== 1'b1 || gpr_we !== 1'b0) begin n_fail++;
         $display("FAIL mul got ill=%0b gw=%0b want 1/0", illegal, gpr_we); end
`endif
      tick();
   endtask

   task automatic test_random();
      logic [24:0] exp_d;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 50) == 0;
         in_pc     = $urandom;
         in_instr  = rand_instr();
         tick();
         n_tests++; if (out_valid !== mo_v || in_ready !== (mq.size() < DEPTH)) begin n_fail++;
            $display("FAIL rnd_hs@%0d got v=%0b r=%0b want %0b/%0b", k, out_valid, in_ready, mo_v, mq.size() < DEPTH); end
         if (mo_v) begin
            exp_d = ref_dec(mo_ins);
            n_tests++; if (out_pc !== mo_pc || out_instr !== mo_ins || act !== exp_d) begin n_fail++;
               $display("FAIL rnd_out@%0d got %h/%h/%h want %h/%h/%h", k, out_pc, out_instr, act, mo_pc, mo_ins, exp_d); end
         end
         n_tests++; if (ill_cnt !== 8'(m_ill) || d2_ill_cnt !== 2'(m_ill2)) begin n_fail++;
            $display("FAIL rnd_cnt@%0d got %0d/%0d want %0d/%0d", k, ill_cnt, d2_ill_cnt, m_ill, m_ill2); end
      end
      flush = 0; in_valid = 0;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_illegal();
      test_flush();
      test_ldst();
      test_mul();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
